logic_fu_pipe: RTL and testbench

- Pipelined, parametrised logic functional unit for the Tomasulo core.
- Accepts dispatched ops from the logic reservation station with a valid/ready handshake and carries each op's ROB tag through LATENCY stages.
- Broadcasts results on the common data bus (CDB) under a request/grant handshake, with backpressure and flush.
- Generalises the combinational 64-bit logic unit in data width, latency and operation set, and adds a tag, a stall path and a flush path.

---
 rtl/logic_pkg.sv | 16 +
 rtl/logic_fu_pipe_if.sv | 34 +++
 rtl/logic_core.sv | 28 ++
 rtl/logic_fu_pipe.sv | 106 ++++++++++
 tb/tb_logic_fu_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
// Shared opcode encodings and default widths for the logic functional unit.
package logic_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int TAG_W_DEFAULT = 5;

    localparam logic [2:0] LOP_AND  = 3'b000;
    localparam logic [2:0] LOP_OR   = 3'b001;
    localparam logic [2:0] LOP_XOR  = 3'b010;
    localparam logic [2:0] LOP_NOR  = 3'b011;
    localparam logic [2:0] LOP_NAND = 3'b100;
    localparam logic [2:0] LOP_XNOR = 3'b101;
    localparam logic [2:0] LOP_NOTA = 3'b110;
    localparam logic [2:0] LOP_ANDN = 3'b111;

endpackage

// File: rtl/logic_fu_pipe_if.sv
// Dispatch, CDB and control bundle between the logic FU and its surroundings.
interface logic_fu_pipe_if
    import logic_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             cdb_req;
    logic             cdb_grant;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             flush;
    logic [2:0]       occupancy;

    // The functional unit side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, cdb_grant, flush,
        output in_ready, cdb_req, cdb_tag, cdb_data, occupancy
    );

    // The reservation station / arbiter side.
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, cdb_grant, flush,
        input  in_ready, cdb_req, cdb_tag, cdb_data, occupancy
    );

endinterface

// File: rtl/logic_core.sv
// Combinational bitwise logic operation over XLEN bits.
module logic_core
    import logic_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            LOP_AND:  y = a & b;
            LOP_OR:   y = a | b;
            LOP_XOR:  y = a ^ b;
            LOP_NOR:  y = ~(a | b);
            LOP_NAND: y = ~(a & b);
            LOP_XNOR: y = ~(a ^ b);
            LOP_NOTA: y = ~a;
            LOP_ANDN: y = a & ~b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_fu_pipe.sv
// Pipelined logic functional unit: computes in stage 0, carries {valid, tag, data}
// through LATENCY stages and broadcasts on the CDB under request/grant.
module logic_fu_pipe
    import logic_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TAG_W   = TAG_W_DEFAULT,
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             rst_n,
    logic_fu_pipe_if.slave  fu
);

    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] stg_load;
    logic [LATENCY-1:0] src_valid;
    logic [XLEN-1:0]    core_y;
    logic               ready;
    logic               in_fire;

    logic_core #(.XLEN(XLEN)) u_core (
        .op (fu.in_op),
        .a  (fu.in_a),
        .b  (fu.in_b),
        .y  (core_y)
    );

    // A stage can load when it is empty or its contents move on this cycle;
    // that reduces to "empty, or the next stage can load" walking back from the CDB.
    always_comb begin
        logic ld;
        stg_load = '0;
        ld = ~stg_valid[LATENCY-1] | fu.cdb_grant;
        stg_load[LATENCY-1] = ld;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            ld = ~stg_valid[i] | ld;
            stg_load[i] = ld;
        end
    end

    assign ready   = stg_load[0] & ~fu.flush;
    assign in_fire = fu.in_valid & ready;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic [TAG_W-1:0] src_tag;
        logic [XLEN-1:0]  src_data;
        logic [TAG_W-1:0] tag_q;
        logic [XLEN-1:0]  data_q;

        if (i == 0) begin : g_src
            assign src_valid[i] = in_fire;
            assign src_tag      = fu.in_tag;
            assign src_data     = core_y;
        end else begin : g_src
            assign src_valid[i] = stg_valid[i-1];
            assign src_tag      = g_stage[i-1].tag_q;
            assign src_data     = g_stage[i-1].data_q;
        end

        // Only the stage facing the CDB needs defined payload out of reset.
        if (i == LATENCY - 1) begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_q  <= '0;
                    data_q <= '0;
                end else if (stg_load[i] && src_valid[i]) begin
                    tag_q  <= src_tag;
                    data_q <= src_data;
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (stg_load[i] && src_valid[i]) begin
                    tag_q  <= src_tag;
                    data_q <= src_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
        end else if (fu.flush) begin
            stg_valid <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (stg_load[i]) stg_valid[i] <= src_valid[i];
            end
        end
    end

    always_comb begin
        fu.occupancy = '0;
        for (int i = 0; i < LATENCY; i++) begin
            fu.occupancy = fu.occupancy + {2'b00, stg_valid[i]};
        end
    end

    assign fu.in_ready = ready;
    assign fu.cdb_req  = stg_valid[LATENCY-1];
    assign fu.cdb_tag  = g_stage[LATENCY-1].tag_q;
    assign fu.cdb_data = g_stage[LATENCY-1].data_q;

endmodule

// File: tb/tb_logic_fu_pipe.sv
// Bench for logic_fu_pipe: directed checks on a 64-bit/LATENCY=2 unit and a
// random stream on 32-bit units with LATENCY=1 and 4, all against a queue model.
module tb_logic_fu_pipe;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_bcast = 0;
    bit   last_ready, last_req, last_acc, last_bcast;
    exp_t qs[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_fu_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();
    logic_fu_pipe_if #(.XLEN(32), .TAG_W(5)) if1 ();
    logic_fu_pipe_if #(.XLEN(32), .TAG_W(5)) if4 ();

    logic_fu_pipe #(.XLEN(64), .TAG_W(5), .LATENCY(2)) dut64 (.clk(clk), .rst_n(rst_n), .fu(if64.slave));
    logic_fu_pipe #(.XLEN(32), .TAG_W(5), .LATENCY(1)) dut1  (.clk(clk), .rst_n(rst_n), .fu(if1.slave));
    logic_fu_pipe #(.XLEN(32), .TAG_W(5), .LATENCY(4)) dut4  (.clk(clk), .rst_n(rst_n), .fu(if4.slave));

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: r = ~(a & b);
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            default: r = a & ~b;
        endcase
        m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return r & m;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping for one unit in one cycle, sampled before the edge.
    task automatic book(input int d, input int lat, input int w, input bit v, input bit rdy,
                        input bit req, input bit g, input bit f, input logic [4:0] otag,
                        input logic [63:0] odata, input logic [2:0] occ, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        exp_t e;
        check($sformatf("u%0d_occupancy", d), 64'(occ), 64'(qs[d].size()));
        if (f) begin
            check($sformatf("u%0d_ready_in_flush", d), 64'(rdy), 64'd0);
            qs[d].delete();
        end else begin
            if (req && g) begin
                check($sformatf("u%0d_bcast_expected", d), 64'(qs[d].size() != 0), 64'd1);
                if (qs[d].size() != 0) begin
                    e = qs[d].pop_front();
                    check($sformatf("u%0d_cdb_tag", d), 64'(otag), 64'(e.tag));
                    check($sformatf("u%0d_cdb_data", d), odata, e.data);
                    check($sformatf("u%0d_min_latency", d), 64'((cyc - e.cyc) >= lat), 64'd1);
                end
            end
            if (v && rdy) begin
                e.tag  = tag;
                e.data = ref_op(op, a, b, w);
                e.cyc  = cyc;
                qs[d].push_back(e);
            end
        end
    endtask

    task automatic step64(input bit v, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input bit g, input bit f);
        @(negedge clk);
        if64.in_valid  = v;
        if64.in_op     = op;
        if64.in_a      = a;
        if64.in_b      = b;
        if64.in_tag    = tag;
        if64.cdb_grant = g;
        if64.flush     = f;
        #1;
        last_ready = if64.in_ready;
        last_req   = if64.cdb_req;
        last_acc   = v && if64.in_ready;
        last_bcast = if64.cdb_req && g && !f;
        if (last_bcast) n_bcast++;
        book(0, 2, 64, v, if64.in_ready, if64.cdb_req, g, f, if64.cdb_tag, if64.cdb_data,
             if64.occupancy, op, a, b, tag);
    endtask

    initial begin
        logic [63:0] pa, pb, ra, rb, exp_a;
        logic [2:0]  rop;
        int          acc_cyc;
        int          bc_before;
        bit          v1, g1, f1, v4, g4, f4;
        logic [2:0]  op1, op4;
        logic [31:0] a1, b1, a4, b4;

        rst_n = 1'b0;
        if64.in_valid = 0; if64.in_op = '0; if64.in_a = '0; if64.in_b = '0;
        if64.in_tag = '0; if64.cdb_grant = 0; if64.flush = 0;
        if1.in_valid = 0; if1.in_op = '0; if1.in_a = '0; if1.in_b = '0;
        if1.in_tag = '0; if1.cdb_grant = 0; if1.flush = 0;
        if4.in_valid = 0; if4.in_op = '0; if4.in_a = '0; if4.in_b = '0;
        if4.in_tag = '0; if4.cdb_grant = 0; if4.flush = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fill the pipe, then pull reset mid-run.
        step64(1, 3'd7, 64'hDEAD_BEEF_0123_4567, 64'h0, 5'd1, 0, 0);
        step64(1, 3'd1, 64'h1234, 64'h8000_0000_0000_0000, 5'd2, 0, 0);
        step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 0, 0);
        check("pre_reset_req", 64'(last_req), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_cdb_req", 64'(if64.cdb_req), 64'd0);
        check("rst_cdb_tag", 64'(if64.cdb_tag), 64'd0);
        check("rst_cdb_data", if64.cdb_data, 64'd0);
        check("rst_occupancy", 64'(if64.occupancy), 64'd0);
        check("rst_in_ready", 64'(if64.in_ready), 64'd1);
        check("rst_u4_occupancy", 64'(if4.occupancy), 64'd0);
        qs[0].delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Single NOR op with grant held.
        step64(1, 3'b011, 64'h4, 64'h10, 5'd3, 1, 0);
        check("single_accept", 64'(last_acc), 64'd1);
        acc_cyc = cyc;
        step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("single_req_early", 64'(last_req), 64'd0);
        step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("single_req", 64'(last_req), 64'd1);
        check("single_data", if64.cdb_data, 64'hFFFF_FFFF_FFFF_FFEB);
        check("single_tag", 64'(if64.cdb_tag), 64'd3);
        check("single_latency", 64'(cyc - acc_cyc), 64'd2);

        // Opcode sweep, back to back.
        pa = 64'hF0F0_F0F0_F0F0_F0F0;
        pb = 64'hFF00_FF00_FF00_FF00;
        bc_before = n_bcast;
        for (int k = 0; k < 8; k++) begin
            step64(1, 3'(k), pa, pb, 5'(k), 1, 0);
            check("sweep_accept", 64'(last_acc), 64'd1);
            if (k >= 2) check("sweep_one_per_cycle", 64'(last_bcast), 64'd1);
        end
        for (int k = 0; k < 3; k++) step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("sweep_count", 64'(n_bcast - bc_before), 64'd8);
        check("sweep_drained", 64'(qs[0].size()), 64'd0);

        // Backpressure.
        rop = 3'($urandom_range(0, 7));
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        exp_a = ref_op(rop, ra, rb, 64);
        step64(1, rop, ra, rb, 5'd10, 0, 0);
        check("bp_acc_a", 64'(last_acc), 64'd1);
        step64(1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 5'd11, 0, 0);
        check("bp_acc_b", 64'(last_acc), 64'd1);
        rop = 3'($urandom_range(0, 7));
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        step64(1, rop, ra, rb, 5'd12, 0, 0);
        check("bp_ready_low", 64'(last_ready), 64'd0);
        check("bp_occ_full", 64'(if64.occupancy), 64'd2);
        check("bp_hold_tag", 64'(if64.cdb_tag), 64'd10);
        check("bp_hold_data", if64.cdb_data, exp_a);
        step64(1, rop, ra, rb, 5'd12, 1, 0);
        check("bp_grant_ready", 64'(last_ready), 64'd1);
        check("bp_grant_bcast", 64'(last_bcast), 64'd1);
        step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 0, 0);
        check("bp_occ_stays", 64'(if64.occupancy), 64'd2);
        for (int k = 0; k < 4; k++) step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("bp_drained", 64'(qs[0].size()), 64'd0);

        // Flush with two in flight.
        step64(1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 5'd20, 0, 0);
        step64(1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 5'd21, 0, 0);
        bc_before = n_bcast;
        step64(1, 3'd0, 64'h5, 64'h6, 5'd22, 1, 1);
        check("flush_no_accept", 64'(last_acc), 64'd0);
        step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("flush_occ", 64'(if64.occupancy), 64'd0);
        check("flush_req", 64'(last_req), 64'd0);
        for (int k = 0; k < 3; k++) step64(0, 3'd0, 64'h0, 64'h0, 5'd0, 1, 0);
        check("flush_no_bcast", 64'(n_bcast - bc_before), 64'd0);

        // Random stream on the 32-bit units.
        for (int n = 0; n < 700; n++) begin
            v1 = n < 690 && $urandom_range(0, 3) != 0;
            g1 = $urandom_range(0, 2) != 0 || n >= 690;
            f1 = n < 690 && $urandom_range(0, 39) == 0;
            v4 = n < 690 && $urandom_range(0, 3) != 0;
            g4 = $urandom_range(0, 2) != 0 || n >= 690;
            f4 = n < 690 && $urandom_range(0, 39) == 0;
            op1 = 3'($urandom_range(0, 7));
            op4 = 3'($urandom_range(0, 7));
            a1 = $urandom; b1 = $urandom; a4 = $urandom; b4 = $urandom;
            @(negedge clk);
            if1.in_valid = v1; if1.in_op = op1; if1.in_a = a1; if1.in_b = b1;
            if1.in_tag = 5'(n); if1.cdb_grant = g1; if1.flush = f1;
            if4.in_valid = v4; if4.in_op = op4; if4.in_a = a4; if4.in_b = b4;
            if4.in_tag = 5'(n + 7); if4.cdb_grant = g4; if4.flush = f4;
            #1;
            book(1, 1, 32, v1, if1.in_ready, if1.cdb_req, g1, f1, if1.cdb_tag,
                 64'(if1.cdb_data), if1.occupancy, op1, 64'(a1), 64'(b1), 5'(n));
            book(2, 4, 32, v4, if4.in_ready, if4.cdb_req, g4, f4, if4.cdb_tag,
                 64'(if4.cdb_data), if4.occupancy, op4, 64'(a4), 64'(b4), 5'(n + 7));
        end
        check("u1_no_loss", 64'(qs[1].size()), 64'd0);
        check("u2_no_loss", 64'(qs[2].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
